// File: rtl/piso_frame_tx.sv
// piso_frame_tx: parallel-in serial-out frame transmitter.
// Frame: start bit (0), WIDTH data bits LSB first, optional parity bit, stop bit (1).
module piso_frame_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1,
  parameter bit          ODD       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             par_q,   par_d;
  logic             so_q,    so_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             accept;

  // Ready is a pure decode of the state register.
  always_comb begin
    din_ready = (state_q == S_IDLE) || (state_q == S_STOP);
  end

  assign accept = din_valid & din_ready;

  // Next-state, datapath and next-output computation.
  // Outputs are registered, so their values are derived from the state being
  // entered (state_d) and the shift register contents after this edge (shreg_d).
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shreg_d = din;
          par_d   = (^din) ^ ODD;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        shreg_d = shreg_q >> 1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
        if (accept) begin
          state_d = S_START;
          shreg_d = din;
          par_d   = (^din) ^ ODD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    so_d = 1'b1;
    unique case (state_d)
      S_START:  so_d = 1'b0;
      S_DATA:   so_d = shreg_d[0];
      S_PARITY: so_d = par_d;
      default:  so_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP);
  end

  // State, datapath and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      so_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign so   = so_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboard bench for piso_frame_tx: three instances cover even parity,
// odd parity and no parity; expected per-cycle outputs are queued per frame.
module tb_piso_frame_tx;

  localparam int W = 8;
  localparam int N = 3;
  // Instance d: PEN[d] parity enable, PODD[d] odd parity.
  localparam logic [N-1:0] PEN  = 3'b011;
  localparam logic [N-1:0] PODD = 3'b010;

  // Expected sample: {so, busy, done, din_ready}
  typedef logic [3:0] exp_t;
  localparam exp_t IDLE_EXP = 4'b1001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din       [N];
  logic         din_valid [N];
  logic         din_ready [N];
  logic         so        [N];
  logic         busy      [N];
  logic         done      [N];

  exp_t exp_q [N][$];
  logic mrdy  [N];
  logic acc   [N];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  piso_frame_tx #(.WIDTH(W), .PARITY_EN(1'b1), .ODD(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .so(so[0]), .busy(busy[0]), .done(done[0]));

  piso_frame_tx #(.WIDTH(W), .PARITY_EN(1'b1), .ODD(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .so(so[1]), .busy(busy[1]), .done(done[1]));

  piso_frame_tx #(.WIDTH(W), .PARITY_EN(1'b0), .ODD(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]),
    .din_ready(din_ready[2]), .so(so[2]), .busy(busy[2]), .done(done[2]));

  // Reference: a frame is the bit string {stop, [parity], data, start} sent LSB first.
  function automatic void push_frame(int d, logic [W-1:0] w);
    logic [W+2:0] fr;
    int           len;
    logic         par;
    par = (^w) ^ PODD[d];
    if (PEN[d]) begin
      fr  = {1'b1, par, w, 1'b0};
      len = W + 3;
    end else begin
      fr  = {1'b0, 1'b1, w, 1'b0};
      len = W + 2;
    end
    for (int k = 0; k < len; k++) begin
      exp_q[d].push_back({fr[k], 1'b1, (k == len - 1), (k == len - 1)});
    end
  endfunction

  function automatic void chk(string name, exp_t got, exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got so/busy/done/rdy=%b required %b", name, $time, got, want);
    end
  endfunction

  // Model handshake: a word is taken when the model's ready for this cycle is set.
  always @(posedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (rst && din_valid[d] && mrdy[d]) begin
        acc[d] <= 1'b1;
        push_frame(d, din[d]);
      end else begin
        acc[d] <= 1'b0;
      end
    end
  end

  // Monitor: one expected sample per cycle, idle values when no frame is queued.
  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      exp_t e;
      e = (exp_q[d].size() > 0) ? exp_q[d].pop_front() : IDLE_EXP;
      chk($sformatf("frame_d%0d", d), {so[d], busy[d], done[d], din_ready[d]}, e);
      mrdy[d] <= e[0];
    end
  end

  task automatic send(int d, logic [W-1:0] w, bit keep);
    int n;
    din[d]       = w;
    din_valid[d] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc[d] && n < 60);
    if (!acc[d]) begin
      errors++;
      $display("FAIL accept_timeout_d%0d: got no accept required accept of %h", d, w);
    end
    if (!keep) din_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q[0].size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      din[d] = '0;
      din_valid[d] = 1'b0;
      mrdy[d] = 1'b1;
      acc[d] = 1'b0;
    end
    #1 rst = 1'b0;
    #2;
    for (int d = 0; d < N; d++)
      chk($sformatf("reset_state_d%0d", d), {so[d], busy[d], done[d], din_ready[d]}, IDLE_EXP);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Known frames: A5 even parity, 01 odd parity, 80 without parity, 01 even parity.
    fork
      send(0, 8'hA5, 1'b0);
      send(1, 8'h01, 1'b0);
      send(2, 8'h80, 1'b0);
    join
    drain();
    send(0, 8'h01, 1'b0);
    drain();

    // Back-to-back frames, second word presented during DATA of the first.
    send(0, 8'hFF, 1'b1);
    send(0, 8'h00, 1'b0);
    drain();

    // Asynchronous reset during data bit 3, then a clean frame.
    send(0, 8'h5A, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_abort", {so[0], busy[0], done[0], din_ready[0]}, IDLE_EXP);
    for (int d = 0; d < N; d++) begin
      exp_q[d].delete();
      mrdy[d] = 1'b1;
    end
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    send(0, 8'h3C, 1'b0);
    drain();

    // Randomised traffic; an offered word is held until it is taken.
    repeat (2000) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < N; d++) begin
        if (!din_valid[d] || acc[d]) begin
          din_valid[d] = ($urandom_range(0, 2) != 0);
          din[d]       = W'($urandom);
        end
      end
    end
    for (int d = 0; d < N; d++) din_valid[d] = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
